memory_dump_reader: RTL and testbench
=====================================

// Module: memory_dump_reader
// PURPOSE
//   Read-side sequencer for the 4-byte memory_system: walks addr 0..NUM_ENTRIES-1,
//   waits for the combinational read mux to settle, captures each byte and presents
//   it on a valid/ready stream with a running 8-bit checksum. It drives memory_system's
//   addr during dumps; top level muxes addr between this block (busy=1) and the switches.
// PARAMETERS
//   DATA_W         8  byte width of memory words and out_data
//   ADDR_W         2  address width driven to memory_system
//   NUM_ENTRIES    4  bytes per dump, 1..2**ADDR_W
//   SETTLE_CYCLES  1  cycles rd_addr is held before sampling rd_data, >=1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   start      in   1       level-sampled; begins a dump when IDLE
//   abort      in   1       cancels a dump in progress
//   rd_addr    out  ADDR_W  address to memory_system
//   rd_data    in   DATA_W  memory output of memory_system
//   out_data   out  DATA_W  captured byte
//   out_valid  out  1       out_data holds a byte
//   out_ready  in   1       consumer accepts byte
//   busy       out  1       dump in progress (SETTLE/PRESENT)
//   done       out  1       one-cycle pulse after last byte accepted
//   checksum   out  DATA_W  sum of bytes captured this dump, mod 2**DATA_W
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, rd_addr=0, out_data=0, out_valid=0,
//     busy=0, done=0, checksum=0, idx=0, settle count=0. Reset mid-dump discards it.
//   All outputs registered. States IDLE, SETTLE, PRESENT, DONE.
//   IDLE: start=1 at edge -> idx=0, rd_addr=0, checksum=0, count=SETTLE_CYCLES-1, SETTLE.
//   SETTLE: rd_addr held; lasts exactly SETTLE_CYCLES cycles. Edge ending final cycle:
//     out_data<=rd_data, checksum<=checksum+rd_data (carry dropped), out_valid<=1, PRESENT.
//   PRESENT: out_valid=1, out_data and rd_addr stable until out_ready=1 at an edge.
//     On handshake: idx==NUM_ENTRIES-1 -> out_valid<=0, DONE; else idx+1, rd_addr+1,
//     out_valid<=0, count reloaded, SETTLE. out_ready=0 holds indefinitely.
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE; rd_addr returns to 0.
//   checksum holds final value after DONE until next accepted start.
//   start while busy or in DONE: ignored (no restart, no queueing).
//   abort=1 at edge in SETTLE/PRESENT: -> IDLE, out_valid=0, rd_addr=0, no done pulse,
//     checksum holds partial sum. abort beats a same-edge handshake. abort in IDLE: no-op.
//   start and abort both high in IDLE: abort wins, stays IDLE.
//   rd_addr never exceeds NUM_ENTRIES-1; no wrap within a dump.
//   Timing, SETTLE_CYCLES=1, out_ready=1: start sampled edge E0; out_valid high in cycles
//     2,4,6,8 after E0 with bytes 0..3; done high cycle 9; 2 cycles/byte.
// TESTING
//   1. Memory 0x12,0x34,0x56,0x78; start, out_ready=1 -> out_data 12,34,56,78 in cycles
//      2,4,6,8; done cycle 9 only; checksum=0x14.
//   2. Memory all 0xFF -> four 0xFF bytes; checksum=0xFC (wrap); busy low from cycle 9.
//   3. out_ready low 5 cycles on byte 1 -> out_valid,out_data=0x34,rd_addr=1 stable;
//      accepted on first ready edge; no byte lost or duplicated.
//   4. start pulsed during PRESENT of byte 2 -> ignored; exactly 4 bytes, one done.
//   5. abort during PRESENT of byte 1 -> next cycle IDLE, out_valid=0, rd_addr=0, no done,
//      checksum=0x46 (12+34); new start gives full dump.
//   6. rst_n low mid-SETTLE -> all outputs reset immediately (async); SETTLE_CYCLES=3 run
//      -> rd_addr held 3 cycles per byte before capture.

Source files
------------

// File: rtl/memory_dump_reader_if.sv
// -----------------------------------------------------------------------------
// memory_dump_reader_if
//   Groups the control, memory-read and byte-stream signals of the
//   memory_dump_reader into one bundle.
//
//   Signals
//     start      environment -> reader   level-sampled dump request
//     abort      environment -> reader   cancel a dump in progress
//     rd_addr    reader -> memory        address presented to memory_system
//     rd_data    memory -> reader        combinational read data
//     out_data   reader -> consumer      captured byte
//     out_valid  reader -> consumer      out_data holds a byte
//     out_ready  consumer -> reader      consumer accepts the byte
//     busy       reader -> environment   dump in progress
//     done       reader -> environment   one-cycle end-of-dump pulse
//     checksum   reader -> environment   running byte sum, modulo 2**DATA_W
//
//   Modports
//     slave   : the reader itself
//     master  : the surrounding environment (controller, memory, consumer)
// -----------------------------------------------------------------------------
interface memory_dump_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    modport slave (
        input  start,
        input  abort,
        input  rd_data,
        input  out_ready,
        output rd_addr,
        output out_data,
        output out_valid,
        output busy,
        output done,
        output checksum
    );

    modport master (
        output start,
        output abort,
        output rd_data,
        output out_ready,
        input  rd_addr,
        input  out_data,
        input  out_valid,
        input  busy,
        input  done,
        input  checksum
    );

endinterface

// File: rtl/memory_dump_reader.sv
// -----------------------------------------------------------------------------
// memory_dump_reader
//   Read-side sequencer for the small memory_system. On request it walks
//   addresses 0..NUM_ENTRIES-1, holds each address for SETTLE_CYCLES cycles so
//   the combinational read mux has settled, captures the byte and offers it on
//   a valid/ready stream while accumulating an 8-bit wrap-around checksum.
//
//   Ports
//     clk    in   single clock, rising edge active
//     rst_n  in   asynchronous active-low reset
//     bus    memory_dump_reader_if.slave
//              start/abort/rd_data/out_ready in,
//              rd_addr/out_data/out_valid/busy/done/checksum out
//
//   Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module memory_dump_reader #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 2,
    parameter int NUM_ENTRIES   = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    memory_dump_reader_if.slave       bus
);

    // Width of the settle down-counter; at least one bit even for SETTLE_CYCLES=1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [DATA_W-1:0]   checksum_q,  checksum_d;

    // Checksum accumulation: plain addition with the carry dropped.
    function automatic logic [DATA_W-1:0] csum_add(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] value
    );
        logic [DATA_W-1:0] sum;
        sum = acc + value;
        return sum;
    endfunction

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;

        case (state_q)
            ST_IDLE: begin
                // abort takes priority over a simultaneous start
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    idx_d      = {ADDR_W{1'b0}};
                    rd_addr_d  = {ADDR_W{1'b0}};
                    checksum_d = {DATA_W{1'b0}};
                    cnt_d      = CNT_LOAD;
                    busy_d     = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    // checksum keeps the partial sum of an aborted dump
                    idx_d       = {ADDR_W{1'b0}};
                    rd_addr_d   = {ADDR_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    // last settle cycle: read mux output is stable now
                    out_data_d  = bus.rd_data;
                    checksum_d  = csum_add(checksum_q, bus.rd_data);
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PRESENT: begin
                // abort wins even if the consumer accepts on the same edge
                if (bus.abort) begin
                    idx_d       = {ADDR_W{1'b0}};
                    rd_addr_d   = {ADDR_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d     = idx_q + ADDR_W'(1);
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        cnt_d     = CNT_LOAD;
                        state_d   = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end

            ST_DONE: begin
                // done_q is high for this single cycle; start is not looked at here
                idx_d     = {ADDR_W{1'b0}};
                rd_addr_d = {ADDR_W{1'b0}};
                cnt_d     = {CNT_W{1'b0}};
                state_d   = ST_IDLE;
            end

            default: begin
                idx_d       = {ADDR_W{1'b0}};
                rd_addr_d   = {ADDR_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_memory_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_memory_dump_reader
//   Directed bench for memory_dump_reader. u_dut1 uses SETTLE_CYCLES=1,
//   u_dut3 uses SETTLE_CYCLES=3; both read from the same 4-byte memory model.
//   Inputs change on the falling edge or just after the rising edge; outputs
//   are sampled on the falling edge. Cycle k means the k-th falling edge
//   after the rising edge that sampled start.
// -----------------------------------------------------------------------------
module tb_memory_dump_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] mem [0:3];

    memory_dump_reader_if #(.DATA_W(8), .ADDR_W(2)) bus1 ();
    memory_dump_reader_if #(.DATA_W(8), .ADDR_W(2)) bus3 ();

    assign bus1.rd_data = mem[bus1.rd_addr];
    assign bus3.rd_data = mem[bus3.rd_addr];

    memory_dump_reader #(.DATA_W(8), .ADDR_W(2), .NUM_ENTRIES(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    memory_dump_reader #(.DATA_W(8), .ADDR_W(2), .NUM_ENTRIES(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int errors = 0;
    int checks = 0;

    // results of run_dump
    logic [7:0] got [0:7];
    int n_got, n_done, done_cyc, stall_obs, stall_bad, extra_act, timed_out;

    task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    endtask

    task automatic kick1();
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
    endtask

    task automatic kick3();
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        #1;
        bus3.start = 1'b0;
    endtask

    // Drives one dump on u_dut1 and records what the consumer saw.
    task automatic run_dump(input int stall_idx, input int stall_len, input int poke_idx);
        int stalled = 0;
        int poked = 0;
        int cyc = 0;
        int post = 0;
        int cur;
        n_got = 0; n_done = 0; done_cyc = 0;
        stall_obs = 0; stall_bad = 0; extra_act = 0;
        bus1.out_ready = 1'b1;
        kick1();
        while (cyc < 60 && post < 4) begin
            @(negedge clk);
            cyc++;
            bus1.start = 1'b0;
            if (n_done > 0) begin
                post++;
                if (bus1.busy || bus1.out_valid || bus1.done) extra_act++;
            end
            if (bus1.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus1.out_valid) begin
                cur = n_got;
                if (cur == stall_idx && stalled < stall_len) begin
                    bus1.out_ready = 1'b0;
                    stalled++;
                    stall_obs++;
                    if (bus1.out_data !== mem[stall_idx] || bus1.rd_addr !== 2'(stall_idx))
                        stall_bad++;
                end else begin
                    bus1.out_ready = 1'b1;
                    if (n_got < 8) got[n_got] = bus1.out_data;
                    n_got++;
                end
                if (poke_idx >= 0 && poked == 0 && cur == poke_idx) begin
                    bus1.start = 1'b1;
                    poked = 1;
                end
            end
        end
        timed_out = (post < 4) ? 1 : 0;
        bus1.out_ready = 1'b1;
        bus1.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b1;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.out_ready = 1'b1;
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        #12;
        checks++; if (bus1.rd_addr !== 2'd0) begin errors++; $display("FAIL reset_rd_addr got=%0h exp=0", bus1.rd_addr); end
        checks++; if (bus1.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", bus1.out_data); end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus1.out_valid); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus1.busy); end
        checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus1.done); end
        checks++; if (bus1.checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got=%0h exp=0", bus1.checksum); end
        checks++; if (bus3.busy !== 1'b0 || bus3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_dut3 busy=%0b valid=%0b exp=0,0", bus3.busy, bus3.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_dump();
        logic       ev, ed, eb;
        logic [1:0] ea;
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        bus1.out_ready = 1'b1;
        kick1();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ev = (k % 2 == 0) && (k <= 8);
            ed = (k == 9);
            eb = (k <= 8);
            ea = 2'((k - 1) / 2);
            checks++; if (bus1.out_valid !== ev) begin errors++; $display("FAIL basic_valid cyc=%0d got=%0b exp=%0b", k, bus1.out_valid, ev); end
            checks++; if (bus1.done !== ed) begin errors++; $display("FAIL basic_done cyc=%0d got=%0b exp=%0b", k, bus1.done, ed); end
            checks++; if (bus1.busy !== eb) begin errors++; $display("FAIL basic_busy cyc=%0d got=%0b exp=%0b", k, bus1.busy, eb); end
            if (k <= 8) begin
                checks++; if (bus1.rd_addr !== ea) begin errors++; $display("FAIL basic_rd_addr cyc=%0d got=%0d exp=%0d", k, bus1.rd_addr, ea); end
            end
            if (ev) begin
                checks++; if (bus1.out_data !== mem[k/2-1]) begin errors++; $display("FAIL basic_data cyc=%0d got=%0h exp=%0h", k, bus1.out_data, mem[k/2-1]); end
            end
        end
        checks++; if (bus1.checksum !== 8'h14) begin errors++; $display("FAIL basic_checksum got=%0h exp=14", bus1.checksum); end
    endtask

    task automatic test_wrap_checksum();
        int nb = 0;
        set_mem(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        bus1.out_ready = 1'b1;
        kick1();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus1.out_valid) begin
                nb++;
                checks++; if (bus1.out_data !== 8'hFF) begin errors++; $display("FAIL wrap_data cyc=%0d got=%0h exp=ff", k, bus1.out_data); end
            end
            if (k >= 9) begin
                checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_low cyc=%0d got=%0b exp=0", k, bus1.busy); end
            end
        end
        checks++; if (nb != 4) begin errors++; $display("FAIL wrap_byte_count got=%0d exp=4", nb); end
        checks++; if (bus1.checksum !== 8'hFC) begin errors++; $display("FAIL wrap_checksum got=%0h exp=fc", bus1.checksum); end
    endtask

    task automatic test_backpressure();
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        run_dump(1, 5, -1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL stall_timeout got=%0d exp=0", timed_out); end
        checks++; if (n_got != 4) begin errors++; $display("FAIL stall_byte_count got=%0d exp=4", n_got); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== mem[i]) begin errors++; $display("FAIL stall_byte%0d got=%0h exp=%0h", i, got[i], mem[i]); end
        end
        checks++; if (stall_obs != 5 || stall_bad != 0) begin errors++; $display("FAIL stall_stable obs=%0d bad=%0d exp=5,0", stall_obs, stall_bad); end
        checks++; if (n_done != 1 || done_cyc != 14) begin errors++; $display("FAIL stall_done count=%0d cyc=%0d exp=1,14", n_done, done_cyc); end
        checks++; if (bus1.checksum !== 8'h14) begin errors++; $display("FAIL stall_checksum got=%0h exp=14", bus1.checksum); end
    endtask

    task automatic test_start_while_busy();
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        run_dump(-1, 0, 2);
        checks++; if (n_got != 4) begin errors++; $display("FAIL busy_start_bytes got=%0d exp=4", n_got); end
        checks++; if (n_done != 1 || done_cyc != 9) begin errors++; $display("FAIL busy_start_done count=%0d cyc=%0d exp=1,9", n_done, done_cyc); end
        checks++; if (extra_act != 0) begin errors++; $display("FAIL busy_start_restart got=%0d exp=0", extra_act); end
        checks++; if (got[2] !== 8'h56 || got[3] !== 8'h78) begin errors++; $display("FAIL busy_start_data got=%0h,%0h exp=56,78", got[2], got[3]); end
    endtask

    task automatic test_abort();
        int nv = 0;
        int found = 0;
        int late_done = 0;
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        bus1.out_ready = 1'b1;
        kick1();
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(negedge clk);
            if (bus1.out_valid) begin
                nv++;
                if (nv == 2) found = 1;
            end
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL abort_wait_byte1 got=timeout exp=valid");
            return;
        end
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.abort = 1'b0;
        @(negedge clk);
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%0b exp=0", bus1.out_valid); end
        checks++; if (bus1.rd_addr !== 2'd0) begin errors++; $display("FAIL abort_rd_addr got=%0d exp=0", bus1.rd_addr); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", bus1.busy); end
        checks++; if (bus1.checksum !== 8'h46) begin errors++; $display("FAIL abort_checksum got=%0h exp=46", bus1.checksum); end
        for (int k = 0; k < 5; k++) begin
            if (bus1.done) late_done++;
            @(negedge clk);
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", late_done); end
        // start and abort together in IDLE: abort wins
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        @(negedge clk);
        checks++; if (bus1.busy !== 1'b0 || bus1.checksum !== 8'h46) begin errors++; $display("FAIL abort_beats_start busy=%0b csum=%0h exp=0,46", bus1.busy, bus1.checksum); end
        run_dump(-1, 0, -1);
        checks++; if (n_got != 4 || n_done != 1) begin errors++; $display("FAIL abort_redump bytes=%0d done=%0d exp=4,1", n_got, n_done); end
        checks++; if (bus1.checksum !== 8'h14) begin errors++; $display("FAIL abort_redump_checksum got=%0h exp=14", bus1.checksum); end
    endtask

    task automatic test_async_reset_settle3();
        logic       ev, ed, eb;
        logic [1:0] ea;
        set_mem(8'h12, 8'h34, 8'h56, 8'h78);
        bus3.out_ready = 1'b1;
        kick3();
        for (int k = 1; k <= 6; k++) @(negedge clk);
        checks++; if (bus3.busy !== 1'b1 || bus3.rd_addr !== 2'd1) begin errors++; $display("FAIL arst_pre busy=%0b addr=%0d exp=1,1", bus3.busy, bus3.rd_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus3.busy !== 1'b0 || bus3.rd_addr !== 2'd0 || bus3.out_valid !== 1'b0) begin errors++; $display("FAIL arst_ctrl busy=%0b addr=%0d valid=%0b exp=0,0,0", bus3.busy, bus3.rd_addr, bus3.out_valid); end
        checks++; if (bus3.out_data !== 8'h00 || bus3.checksum !== 8'h00 || bus3.done !== 1'b0) begin errors++; $display("FAIL arst_data data=%0h csum=%0h done=%0b exp=0,0,0", bus3.out_data, bus3.checksum, bus3.done); end
        @(negedge clk);
        rst_n = 1'b1;
        kick3();
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            ev = (k % 4 == 0) && (k <= 16);
            ed = (k == 17);
            eb = (k <= 16);
            ea = 2'((k - 1) / 4);
            checks++; if (bus3.out_valid !== ev) begin errors++; $display("FAIL s3_valid cyc=%0d got=%0b exp=%0b", k, bus3.out_valid, ev); end
            checks++; if (bus3.done !== ed || bus3.busy !== eb) begin errors++; $display("FAIL s3_done_busy cyc=%0d got=%0b,%0b exp=%0b,%0b", k, bus3.done, bus3.busy, ed, eb); end
            if (k <= 16) begin
                checks++; if (bus3.rd_addr !== ea) begin errors++; $display("FAIL s3_rd_addr cyc=%0d got=%0d exp=%0d", k, bus3.rd_addr, ea); end
            end
            if (ev) begin
                checks++; if (bus3.out_data !== mem[k/4-1]) begin errors++; $display("FAIL s3_data cyc=%0d got=%0h exp=%0h", k, bus3.out_data, mem[k/4-1]); end
            end
        end
        checks++; if (bus3.checksum !== 8'h14) begin errors++; $display("FAIL s3_checksum got=%0h exp=14", bus3.checksum); end
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_wrap_checksum();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_async_reset_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
